// File: rtl/vsfx_issue_align.sv
// ---------------------------------------------------------------------------
// vsfx_issue_align
//   Alignment stage in front of the VSFX (vector simple fixed-point) unit.
//   Three independent in-order streams (decoded instruction, VRA operand and
//   VRB operand) are each buffered in a small circular FIFO. When all three
//   heads are present, and the unit is neither stalled nor flushed, the heads
//   pop together. One cycle later the three issue strobes pulse together with
//   the registered head data.
//
//   Build option: define VSFX_ISSUE_STAT_EN to add the stall and starvation
//   statistics counters and their ports.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   flush                    synchronous flush: empties all lanes and beats
//                            any push or issue in the same cycle
//   ins_valid/data/ready     instruction stream; ready is registered
//   vra_valid/data/ready     VRA operand stream; ready is registered
//   vrb_valid/data/ready     VRB operand stream; ready is registered
//   vsfx_stall               VSFX cannot take a new op this cycle
//   vsfx_ins_en, vsfx_ins    issue strobe and issued instruction
//   vsfx_vra_en, vsfx_vra    issue strobe and issued VRA (same as ins_en)
//   vsfx_vrb_en, vsfx_vrb    issue strobe and issued VRB (same as ins_en)
//   stat_stall_cnt           [VSFX_ISSUE_STAT_EN] cycles with an op ready
//                            to issue but the unit stalled
//   stat_starve_cnt          [VSFX_ISSUE_STAT_EN] cycles with an instruction
//                            waiting for at least one operand
// ---------------------------------------------------------------------------

// One lane: a pointer-wrapped circular buffer with a registered ready.
// Ready reflects the count after this edge, so a full lane that pops only
// becomes ready in the following cycle (no push/pop bypass).
module vsfx_issue_lane #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         valid,
    input  logic [W-1:0] data,
    output logic         ready,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         nonempty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;

    assign push     = valid && ready && !flush;
    assign nonempty = (count != '0);
    assign head     = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            ready <= (count_next < FULL);
        end
    end

    // Storage holds data only; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end
endmodule

module vsfx_issue_align #(
    parameter int DEPTH = 4,
    parameter int INS_W = 32,
    parameter int VR_W  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ins_valid,
    input  logic [INS_W-1:0] ins_data,
    output logic             ins_ready,
    input  logic             vra_valid,
    input  logic [VR_W-1:0]  vra_data,
    output logic             vra_ready,
    input  logic             vrb_valid,
    input  logic [VR_W-1:0]  vrb_data,
    output logic             vrb_ready,
    input  logic             vsfx_stall,
    output logic             vsfx_ins_en,
    output logic [INS_W-1:0] vsfx_ins,
    output logic             vsfx_vra_en,
    output logic [VR_W-1:0]  vsfx_vra,
    output logic             vsfx_vrb_en,
    output logic [VR_W-1:0]  vsfx_vrb
`ifdef VSFX_ISSUE_STAT_EN
   ,output logic [31:0]      stat_stall_cnt,
    output logic [31:0]      stat_starve_cnt
`endif
);
    logic             ins_ne, vra_ne, vrb_ne;
    logic [INS_W-1:0] ins_head;
    logic [VR_W-1:0]  vra_head, vrb_head;
    logic             heads_present;
    logic             issue_p0;
    logic             vld_p1;
    logic [INS_W-1:0] ins_p1;
    logic [VR_W-1:0]  vra_p1, vrb_p1;

    vsfx_issue_lane #(.DEPTH(DEPTH), .W(INS_W)) u_ins (
        .clk(clk), .rst(rst), .flush(flush),
        .valid(ins_valid), .data(ins_data), .ready(ins_ready),
        .pop(issue_p0), .head(ins_head), .nonempty(ins_ne)
    );

    vsfx_issue_lane #(.DEPTH(DEPTH), .W(VR_W)) u_vra (
        .clk(clk), .rst(rst), .flush(flush),
        .valid(vra_valid), .data(vra_data), .ready(vra_ready),
        .pop(issue_p0), .head(vra_head), .nonempty(vra_ne)
    );

    vsfx_issue_lane #(.DEPTH(DEPTH), .W(VR_W)) u_vrb (
        .clk(clk), .rst(rst), .flush(flush),
        .valid(vrb_valid), .data(vrb_data), .ready(vrb_ready),
        .pop(issue_p0), .head(vrb_head), .nonempty(vrb_ne)
    );

    // ---- stage p0: issue decision on the lane heads ----
    assign heads_present = ins_ne && vra_ne && vrb_ne;
    assign issue_p0      = heads_present && !vsfx_stall && !flush;

    // ---- stage p1: registered issue strobe and data ----
    // Data resets to zero because the outputs must read zero during reset;
    // otherwise it only loads on issue and holds the last issued op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            ins_p1 <= '0;
            vra_p1 <= '0;
            vrb_p1 <= '0;
        end else begin
            vld_p1 <= issue_p0;
            if (issue_p0) begin
                ins_p1 <= ins_head;
                vra_p1 <= vra_head;
                vrb_p1 <= vrb_head;
            end
        end
    end

    assign vsfx_ins_en = vld_p1;
    assign vsfx_vra_en = vld_p1;
    assign vsfx_vrb_en = vld_p1;
    assign vsfx_ins    = ins_p1;
    assign vsfx_vra    = vra_p1;
    assign vsfx_vrb    = vrb_p1;

`ifdef VSFX_ISSUE_STAT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cnt  <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (heads_present && vsfx_stall)
                stat_stall_cnt <= sat_inc(stat_stall_cnt);
            if (ins_ne && (!vra_ne || !vrb_ne))
                stat_starve_cnt <= sat_inc(stat_starve_cnt);
        end
    end
`endif
endmodule
